// File: rtl/ysyx_041514_csr_regfile_pkg.sv
// Shared constants for the M-mode CSR register file: addresses, write masks, reset values.
// Optional counters are controlled by the YSYX_041514_CSR_COUNTER_EN macro.
package ysyx_041514_csr_regfile_pkg;

  localparam int XLEN       = 64;
  localparam int CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MSTATUS_RST_DEF = 64'h0000_000A_0000_1800;
  localparam logic [XLEN-1:0] MTVEC_RST_DEF   = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] MISA_VAL_DEF    = 64'h8000_0000_0000_1100;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
  localparam logic [XLEN-1:0] MIE_WMASK     = 64'h0000_0000_0000_0888;
  localparam logic [XLEN-1:0] MIP_WMASK     = 64'h0000_0000_0000_0088;
  localparam logic [XLEN-1:0] ALIGN4_MASK   = 64'hFFFF_FFFF_FFFF_FFFC;

  // The top two address bits equal to 2'b11 mark a read-only CSR.
  function automatic logic csrReadOnly(input logic [CSR_ADDR_W-1:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/ysyx_041514_csr_regfile_if.sv
// Bus bundle between exe/wb/clint and the CSR register file; master drives requests, slave is the regfile.
interface ysyx_041514_csr_regfile_if;
  import ysyx_041514_csr_regfile_pkg::*;

  logic [CSR_ADDR_W-1:0] csr_raddr_i;
  logic [XLEN-1:0]       csr_rdata_o;
  logic                  csr_illegal_o;
  logic                  csr_we_chk_i;
  logic                  csr_write_valid_i;
  logic [CSR_ADDR_W-1:0] csr_waddr_i;
  logic [XLEN-1:0]       csr_wdata_i;
  logic                  instret_valid_i;

  logic [XLEN-1:0] csr_mstatus_writedata_i;
  logic [XLEN-1:0] csr_mepc_writedata_i;
  logic [XLEN-1:0] csr_mcause_writedata_i;
  logic [XLEN-1:0] csr_mtval_writedata_i;
  logic [XLEN-1:0] csr_mip_writedata_i;
  logic            csr_mstatus_write_valid_i;
  logic            csr_mepc_write_valid_i;
  logic            csr_mcause_write_valid_i;
  logic            csr_mtval_write_valid_i;
  logic            csr_mip_write_valid_i;

  logic [XLEN-1:0] csr_mstatus_readdata_o;
  logic [XLEN-1:0] csr_mepc_readdata_o;
  logic [XLEN-1:0] csr_mtvec_readdata_o;
  logic [XLEN-1:0] csr_mip_readdata_o;
  logic [XLEN-1:0] csr_mie_readdata_o;

  modport master (
    output csr_raddr_i, csr_we_chk_i, csr_write_valid_i, csr_waddr_i, csr_wdata_i, instret_valid_i,
    output csr_mstatus_writedata_i, csr_mepc_writedata_i, csr_mcause_writedata_i,
    output csr_mtval_writedata_i, csr_mip_writedata_i,
    output csr_mstatus_write_valid_i, csr_mepc_write_valid_i, csr_mcause_write_valid_i,
    output csr_mtval_write_valid_i, csr_mip_write_valid_i,
    input  csr_rdata_o, csr_illegal_o,
    input  csr_mstatus_readdata_o, csr_mepc_readdata_o, csr_mtvec_readdata_o,
    input  csr_mip_readdata_o, csr_mie_readdata_o
  );

  modport slave (
    input  csr_raddr_i, csr_we_chk_i, csr_write_valid_i, csr_waddr_i, csr_wdata_i, instret_valid_i,
    input  csr_mstatus_writedata_i, csr_mepc_writedata_i, csr_mcause_writedata_i,
    input  csr_mtval_writedata_i, csr_mip_writedata_i,
    input  csr_mstatus_write_valid_i, csr_mepc_write_valid_i, csr_mcause_write_valid_i,
    input  csr_mtval_write_valid_i, csr_mip_write_valid_i,
    output csr_rdata_o, csr_illegal_o,
    output csr_mstatus_readdata_o, csr_mepc_readdata_o, csr_mtvec_readdata_o,
    output csr_mip_readdata_o, csr_mie_readdata_o
  );

endinterface

// File: rtl/ysyx_041514_csr_counter.sv
// 64-bit free-running counter with async reset; a load takes priority over the increment.
module ysyx_041514_csr_counter
  import ysyx_041514_csr_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_data_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] count_o
);

  logic [XLEN-1:0] count_q;
  logic [XLEN-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_data_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ysyx_041514_csr_regfile.sv
// M-mode CSR register file: Zicsr read/write ports plus clint trap-side writes.
// Define YSYX_041514_CSR_COUNTER_EN to build the mcycle/minstret counters.
module ysyx_041514_csr_regfile
  import ysyx_041514_csr_regfile_pkg::*;
#(
  parameter logic [XLEN-1:0] MSTATUS_RST = MSTATUS_RST_DEF,
  parameter logic [XLEN-1:0] MTVEC_RST   = MTVEC_RST_DEF,
  parameter logic [XLEN-1:0] MISA_VAL    = MISA_VAL_DEF
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_041514_csr_regfile_if.slave bus
);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;

  logic [XLEN-1:0] wdata;
  logic            instWr;
  logic [XLEN-1:0] rdata;
  logic            implemented;

  assign instWr = bus.csr_write_valid_i;
  assign wdata  = bus.csr_wdata_i;

  // Clint strobes win over a same-cycle instruction write; that instruction is being flushed.
  always_comb begin
    mstatus_d  = mstatus_q;
    mepc_d     = mepc_q;
    mtvec_d    = mtvec_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = mip_q;
    mie_d      = mie_q;
    mscratch_d = mscratch_q;

    if (bus.csr_mstatus_write_valid_i) begin
      mstatus_d = bus.csr_mstatus_writedata_i;
    end else if (instWr && bus.csr_waddr_i == CSR_MSTATUS) begin
      mstatus_d = (mstatus_q & ~MSTATUS_WMASK) | (wdata & MSTATUS_WMASK);
    end
    mstatus_d[12:11] = 2'b11;

    if (bus.csr_mepc_write_valid_i) begin
      mepc_d = bus.csr_mepc_writedata_i;
    end else if (instWr && bus.csr_waddr_i == CSR_MEPC) begin
      mepc_d = wdata & ALIGN4_MASK;
    end

    if (bus.csr_mcause_write_valid_i) begin
      mcause_d = bus.csr_mcause_writedata_i;
    end else if (instWr && bus.csr_waddr_i == CSR_MCAUSE) begin
      mcause_d = wdata;
    end

    if (bus.csr_mtval_write_valid_i) begin
      mtval_d = bus.csr_mtval_writedata_i;
    end else if (instWr && bus.csr_waddr_i == CSR_MTVAL) begin
      mtval_d = wdata;
    end

    if (bus.csr_mip_write_valid_i) begin
      mip_d = bus.csr_mip_writedata_i;
    end else if (instWr && bus.csr_waddr_i == CSR_MIP) begin
      mip_d = (mip_q & ~MIP_WMASK) | (wdata & MIP_WMASK);
    end

    if (instWr && bus.csr_waddr_i == CSR_MTVEC) begin
      mtvec_d = wdata & ALIGN4_MASK;
    end
    if (instWr && bus.csr_waddr_i == CSR_MIE) begin
      mie_d = wdata & MIE_WMASK;
    end
    if (instWr && bus.csr_waddr_i == CSR_MSCRATCH) begin
      mscratch_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mepc_q     <= '0;
      mtvec_q    <= MTVEC_RST;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      mie_q      <= '0;
      mscratch_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mepc_q     <= mepc_d;
      mtvec_q    <= mtvec_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
      mie_q      <= mie_d;
      mscratch_q <= mscratch_d;
    end
  end

`ifdef YSYX_041514_CSR_COUNTER_EN
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  ysyx_041514_csr_counter u_mcycle (
    .clk         (clk),
    .rst         (rst),
    .load_i      (instWr && bus.csr_waddr_i == CSR_MCYCLE),
    .load_data_i (wdata),
    .inc_i       (1'b1),
    .count_o     (mcycle)
  );

  ysyx_041514_csr_counter u_minstret (
    .clk         (clk),
    .rst         (rst),
    .load_i      (instWr && bus.csr_waddr_i == CSR_MINSTRET),
    .load_data_i (wdata),
    .inc_i       (bus.instret_valid_i),
    .count_o     (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = bus.instret_valid_i;
`endif

  always_comb begin
    rdata       = '0;
    implemented = 1'b1;
    case (bus.csr_raddr_i)
      CSR_MSTATUS:  rdata = mstatus_q;
      CSR_MISA:     rdata = MISA_VAL;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = mip_q;
      CSR_MHARTID:  rdata = '0;
`ifdef YSYX_041514_CSR_COUNTER_EN
      CSR_MCYCLE:   rdata = mcycle;
      CSR_MINSTRET: rdata = minstret;
`endif
      default:      implemented = 1'b0;
    endcase
  end

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = !implemented || (bus.csr_we_chk_i && csrReadOnly(bus.csr_raddr_i));

  assign bus.csr_mstatus_readdata_o = mstatus_q;
  assign bus.csr_mepc_readdata_o    = mepc_q;
  assign bus.csr_mtvec_readdata_o   = mtvec_q;
  assign bus.csr_mip_readdata_o     = mip_q;
  assign bus.csr_mie_readdata_o     = mie_q;

endmodule

// File: tb/tb_ysyx_041514_csr_regfile.sv
// Directed self-checking bench for ysyx_041514_csr_regfile; counter checks follow YSYX_041514_CSR_COUNTER_EN.
module tb_ysyx_041514_csr_regfile;
  import ysyx_041514_csr_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passCount  = 0;
  int   failCount  = 0;
  int   totalCount = 0;

  ysyx_041514_csr_regfile_if bus ();

  ysyx_041514_csr_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr, input logic weChk,
                           input logic [63:0] expData, input logic expIllegal);
    bus.csr_raddr_i  = addr;
    bus.csr_we_chk_i = weChk;
    #1;
    checkOutput({tag, "_rdata"}, bus.csr_rdata_o, expData);
    checkOutput({tag, "_illegal"}, {63'b0, bus.csr_illegal_o}, {63'b0, expIllegal});
    bus.csr_we_chk_i = 1'b0;
  endtask

  // One-cycle wb write; called at a negedge and returns at the following negedge.
  task automatic applyStimulus(input logic [11:0] waddr, input logic [63:0] wdata);
    bus.csr_waddr_i       = waddr;
    bus.csr_wdata_i       = wdata;
    bus.csr_write_valid_i = 1'b1;
    @(negedge clk);
    bus.csr_write_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.csr_raddr_i = '0;
    bus.csr_we_chk_i = 1'b0;
    bus.csr_write_valid_i = 1'b0;
    bus.csr_waddr_i = '0;
    bus.csr_wdata_i = '0;
    bus.instret_valid_i = 1'b0;
    bus.csr_mstatus_writedata_i = '0;
    bus.csr_mepc_writedata_i = '0;
    bus.csr_mcause_writedata_i = '0;
    bus.csr_mtval_writedata_i = '0;
    bus.csr_mip_writedata_i = '0;
    bus.csr_mstatus_write_valid_i = 1'b0;
    bus.csr_mepc_write_valid_i = 1'b0;
    bus.csr_mcause_write_valid_i = 1'b0;
    bus.csr_mtval_write_valid_i = 1'b0;
    bus.csr_mip_write_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    readCheck("rst_mstatus", 12'h300, 1'b0, 64'h0000_000A_0000_1800, 1'b0);
    readCheck("rst_mtvec", 12'h305, 1'b0, 64'h0000_0000_8000_0000, 1'b0);
    readCheck("rst_mepc", 12'h341, 1'b0, 64'h0, 1'b0);

    applyStimulus(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    readCheck("mstatus_mask", 12'h300, 1'b0, 64'h0000_000A_0000_1888, 1'b0);
    checkOutput("mstatus_to_clint", bus.csr_mstatus_readdata_o, 64'h0000_000A_0000_1888);
    applyStimulus(12'h305, 64'h0000_0000_8000_0103);
    readCheck("mtvec_align", 12'h305, 1'b0, 64'h0000_0000_8000_0100, 1'b0);
    applyStimulus(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
    readCheck("mie_mask", 12'h304, 1'b0, 64'h888, 1'b0);

    // Reset asserted while a write is being strobed: the write must be lost.
    bus.csr_waddr_i = 12'h341;
    bus.csr_wdata_i = 64'h1234;
    bus.csr_write_valid_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.csr_write_valid_i = 1'b0;
    readCheck("midrst_mstatus", 12'h300, 1'b0, 64'h0000_000A_0000_1800, 1'b0);
    readCheck("midrst_mtvec", 12'h305, 1'b0, 64'h0000_0000_8000_0000, 1'b0);
    readCheck("midrst_mepc", 12'h341, 1'b0, 64'h0, 1'b0);
    readCheck("midrst_mie", 12'h304, 1'b0, 64'h0, 1'b0);

    applyStimulus(12'h341, 64'h0000_0000_8000_0123);
    readCheck("mepc_align", 12'h341, 1'b0, 64'h0000_0000_8000_0120, 1'b0);
    applyStimulus(12'h301, 64'h0);
    readCheck("misa_ro", 12'h301, 1'b0, 64'h8000_0000_0000_1100, 1'b0);

    bus.csr_mepc_writedata_i = 64'h0000_0000_8000_1000;
    bus.csr_mepc_write_valid_i = 1'b1;
    applyStimulus(12'h341, 64'h5);
    bus.csr_mepc_write_valid_i = 1'b0;
    readCheck("mepc_clint_wins", 12'h341, 1'b0, 64'h0000_0000_8000_1000, 1'b0);
    checkOutput("mepc_to_clint", bus.csr_mepc_readdata_o, 64'h0000_0000_8000_1000);

    bus.csr_mip_writedata_i = 64'h80;
    bus.csr_mip_write_valid_i = 1'b1;
    applyStimulus(12'h344, 64'h0);
    bus.csr_mip_write_valid_i = 1'b0;
    checkOutput("mip_set_wins", bus.csr_mip_readdata_o, 64'h80);
    applyStimulus(12'h344, 64'h0);
    readCheck("mip_sw_clear", 12'h344, 1'b0, 64'h0, 1'b0);
    applyStimulus(12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
    readCheck("mip_mask", 12'h344, 1'b0, 64'h88, 1'b0);

    bus.csr_mstatus_writedata_i = 64'h0;
    bus.csr_mstatus_write_valid_i = 1'b1;
    bus.csr_mcause_writedata_i = 64'h8000_0000_0000_0007;
    bus.csr_mcause_write_valid_i = 1'b1;
    applyStimulus(12'h342, 64'h2);
    bus.csr_mstatus_write_valid_i = 1'b0;
    bus.csr_mcause_write_valid_i = 1'b0;
    readCheck("mstatus_trap_mpp", 12'h300, 1'b0, 64'h1800, 1'b0);
    readCheck("mcause_clint_wins", 12'h342, 1'b0, 64'h8000_0000_0000_0007, 1'b0);

    applyStimulus(12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    readCheck("mscratch_full", 12'h340, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    applyStimulus(12'h343, 64'h0123_4567_89AB_CDEF);
    readCheck("mtval_full", 12'h343, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);

    readCheck("unimpl_7c0", 12'h7C0, 1'b0, 64'h0, 1'b1);
    readCheck("mhartid_we", 12'hF14, 1'b1, 64'h0, 1'b1);
    readCheck("mhartid_rd", 12'hF14, 1'b0, 64'h0, 1'b0);
    readCheck("mtvec_we_legal", 12'h305, 1'b1, 64'h0000_0000_8000_0000, 1'b0);

`ifdef YSYX_041514_CSR_COUNTER_EN
    applyStimulus(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    readCheck("mcycle_preload", 12'hB00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge clk);
    readCheck("mcycle_wrap", 12'hB00, 1'b0, 64'h0, 1'b0);
    bus.instret_valid_i = 1'b1;
    applyStimulus(12'hB02, 64'h5);
    readCheck("minstret_load_wins", 12'hB02, 1'b0, 64'h5, 1'b0);
    @(negedge clk);
    bus.instret_valid_i = 1'b0;
    readCheck("minstret_inc", 12'hB02, 1'b0, 64'h6, 1'b0);
    @(negedge clk);
    readCheck("minstret_hold", 12'hB02, 1'b0, 64'h6, 1'b0);
`else
    bus.instret_valid_i = 1'b1;
    applyStimulus(12'hB00, 64'h5);
    bus.instret_valid_i = 1'b0;
    readCheck("mcycle_absent", 12'hB00, 1'b0, 64'h0, 1'b1);
    readCheck("minstret_absent", 12'hB02, 1'b0, 64'h0, 1'b1);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
